systolic_result_drain: RTL and testbench
========================================

// Module: systolic_result_drain
// PURPOSE
//   Consumer at the output end of the NxN systolic PE array.
//   - Watches the per-PE done flags and captures each PE's 16-bit result once.
//   - Buffers the full N*N result set.
//   - Streams it out in row-major order (PE index i*N+j) over a valid/ready
//     interface to the NPU writeback path.
//   - Turns the array's parallel, unsynchronised completion into one ordered
//     result stream per matrix job.
// PARAMETERS
//   N       2                  array dimension; the array has N*N PEs
//   W       16                 result width per PE
//   NUM_PE  N*N (localparam)   number of results per job
//   IW      max(1,$clog2(NUM_PE)) (localparam)  index width
// PORTS
//   clk        in   1           rising-edge clock
//   rst        in   1           asynchronous active-low reset
//   start      in   1           arm a new job; honoured only in IDLE
//   pe_out     in   W x NUM_PE  unpacked array of PE results, index i*N+j
//   pe_done    in   NUM_PE      per-PE result-valid level flags
//   m_valid    out  1           stream data valid
//   m_ready    in   1           downstream accept
//   m_data     out  W           result value
//   m_index    out  IW          PE index of m_data
//   m_last     out  1           high with the final result of a job
//   busy       out  1           state != IDLE
//   overrun    out  1           sticky: a done flag was seen for an already-captured PE
// BEHAVIOUR
//   Reset (rst=0, async)
//     - State goes to IDLE.
//     - m_valid, m_last, busy, overrun, m_data, m_index, and all captured bits clear to 0.
//     - Buffer contents are don't-care.
//   FSM
//     - IDLE -> COLLECT on start=1. This clears the captured mask and overrun.
//     - COLLECT: each cycle, for every k with pe_done[k]=1 and captured[k]=0:
//       buf[k] <= pe_out[k] and captured[k] <= 1. Several PEs may be captured
//       in the same cycle.
//     - COLLECT -> DRAIN on the edge where the captured mask becomes all-ones
//       (including the captures made on that edge).
//     - DRAIN: cnt starts at 0. m_valid=1, m_data=buf[cnt], m_index=cnt,
//       m_last=(cnt==NUM_PE-1). On m_valid&&m_ready, cnt increments.
//     - DRAIN -> IDLE on the handshake with m_last=1. m_valid drops the next cycle.
//   Timing
//     - All outputs are registered.
//     - If the last capture edge is at cycle t, m_valid rises at t+1 with index 0.
//     - With m_ready held high, one result per cycle: NUM_PE beats in NUM_PE cycles.
//   Handshake rules
//     - While m_valid=1 and m_ready=0, m_data, m_index and m_last stay stable.
//     - m_valid never drops without a handshake, except on reset.
//     - A ready with no valid has no effect.
//   Boundary conditions
//     - start outside IDLE is ignored.
//     - start on the same cycle as the final DRAIN handshake is ignored; it must
//       be reissued in IDLE.
//     - pe_done[k]=1 with captured[k]=1 in COLLECT or DRAIN: no recapture, and
//       overrun <= 1. overrun stays set until the next accepted start.
//     - pe_done in IDLE is ignored and does not set overrun.
//     - Reset mid-COLLECT or mid-DRAIN aborts the job. No partial stream resumes.
//     - cnt never wraps past NUM_PE-1; the exit to IDLE happens first.
//   Arithmetic
//     - Results are passed through unmodified. No truncation or sign handling.
// STRUCTURE
//   - Shared package npu_pkg holds:
//     - typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} drain_state_t
//     - localparam RESULT_W = 16, the default for W
//   - Single flat module. No sub-module is needed: the buffer is a flop array
//     indexed by cnt, with a NUM_PE:1 read mux.
// TESTING (N=2, W=16)
//   1. Basic: start; pe_done=4'b1111 in one cycle, pe_out={40,30,20,10}
//      (index 3..0); m_ready=1
//      -> 4 beats on consecutive cycles: (0,10), (1,20), (2,30), (3,40,last);
//         busy falls after beat 3.
//   2. Staggered done: pe_done bits rise at cycles 2, 3, 3, 5 in order 0, 1, 2, 3
//      -> m_valid rises cycle 6; stream order stays 0..3 regardless of done order.
//   3. Backpressure: m_ready toggled 1,0,0,1,0,1,1 during DRAIN
//      -> data/index stable through stalls; exactly 4 handshakes; m_last only on index 3.
//   4. Overrun: PE0 done again with pe_out=99 after capture
//      -> overrun=1, beat 0 still 10; next start clears overrun.
//   5. Reset mid-DRAIN after beat 1 (rst low 1 cycle)
//      -> all outputs 0 and IDLE; new start + job streams from index 0.
//   6. Ignored start: start pulsed in COLLECT and in DRAIN
//      -> no mask clear, stream unaffected.

Source files
------------

// File: rtl/npu_pkg.sv
// npu_pkg: shared NPU types and default widths.
package npu_pkg;
    typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} drain_state_t;
    localparam int RESULT_W = 16;
endpackage

// File: rtl/systolic_result_drain.sv
// systolic_result_drain: captures each PE result once per job and streams the
// full set out in PE-index order over valid/ready.
module systolic_result_drain import npu_pkg::*; #(
    parameter int N = 2,
    parameter int W = RESULT_W,
    localparam int NUM_PE = N * N,
    localparam int IW = (NUM_PE > 1) ? $clog2(NUM_PE) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [W-1:0]      pe_out [NUM_PE],
    input  logic [NUM_PE-1:0] pe_done,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [W-1:0]      m_data,
    output logic [IW-1:0]     m_index,
    output logic              m_last,
    output logic              busy,
    output logic              overrun
);
    drain_state_t r_state, w_next;
    logic [NUM_PE-1:0] r_captured, w_cap_new, w_mask_next;
    logic [W-1:0]      r_buf [NUM_PE];
    logic [IW-1:0]     r_cnt, w_cnt_inc;
    logic              w_ovr, w_start_ok, w_enter_drain, w_hs;

    assign w_cap_new     = (r_state == COLLECT) ? (pe_done & ~r_captured) : '0;
    assign w_mask_next   = r_captured | w_cap_new;
    assign w_ovr         = (r_state != IDLE) && |(pe_done & r_captured);
    assign w_start_ok    = (r_state == IDLE) && start;
    assign w_enter_drain = (r_state == COLLECT) && (w_next == DRAIN);
    assign w_hs          = (r_state == DRAIN) && m_ready;
    assign w_cnt_inc     = r_cnt + IW'(1);
    assign m_index       = r_cnt;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = COLLECT;
            COLLECT: if (&w_mask_next) w_next = DRAIN;
            DRAIN:   if (m_ready && m_last) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    // Buffer needs no reset: every entry is rewritten before it can be drained.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_PE; k++)
            if (w_cap_new[k]) r_buf[k] <= pe_out[k];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_captured <= '0;
            r_cnt      <= '0;
            m_valid    <= 1'b0;
            m_data     <= '0;
            m_last     <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            busy <= (w_next != IDLE);
            if (w_start_ok) begin
                r_captured <= '0;
                overrun    <= 1'b0;
            end else begin
                r_captured <= w_mask_next;
                if (w_ovr) overrun <= 1'b1;
            end
            // Beat 0 may come from a capture on this very edge, so bypass the buffer.
            if (w_enter_drain) begin
                m_valid <= 1'b1;
                r_cnt   <= '0;
                m_data  <= w_cap_new[0] ? pe_out[0] : r_buf[0];
                m_last  <= (NUM_PE == 1);
            end else if (w_hs) begin
                if (m_last) begin
                    m_valid <= 1'b0;
                    m_last  <= 1'b0;
                end else begin
                    r_cnt  <= w_cnt_inc;
                    m_data <= r_buf[w_cnt_inc];
                    m_last <= (w_cnt_inc == IW'(NUM_PE - 1));
                end
            end
        end
    end
endmodule

// File: tb/tb_systolic_result_drain.sv
// tb_systolic_result_drain: randomized jobs checked against a per-job
// first-capture/ordered-stream model, plus directed basic, overrun and reset cases.
module tb_systolic_result_drain;
    localparam int NUM_PE = 4;

    logic        clk = 1'b0;
    logic        rst, start, m_ready;
    logic [15:0] pe_out [NUM_PE];
    logic [NUM_PE-1:0] pe_done;
    logic        m_valid, m_last, busy, overrun;
    logic [15:0] m_data;
    logic [1:0]  m_index;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] exp_buf [NUM_PE];
    bit          exp_ovr;

    systolic_result_drain #(.N(2), .W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .pe_out(pe_out), .pe_done(pe_done),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_index(m_index),
        .m_last(m_last), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic job_start;
        start   = 1'b1;
        m_ready = 1'($urandom_range(1));
        tick;
        start   = 1'b0;
        exp_ovr = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_overrun_clear", overrun, 0);
        chk("start_valid", m_valid, 0);
    endtask

    task automatic collect(input int p_done, input bit ovr_inject, input bit stray_start);
        bit cap [NUM_PE];
        int left = NUM_PE;
        int guard = 0;
        while (left > 0 && guard < 500) begin
            pe_done = '0;
            for (int k = 0; k < NUM_PE; k++) begin
                pe_out[k] = 16'($urandom);
                if (!cap[k] && $urandom_range(99) < p_done) begin
                    pe_done[k] = 1'b1;
                    cap[k]     = 1'b1;
                    exp_buf[k] = pe_out[k];
                    left--;
                end else if (cap[k] && ovr_inject && $urandom_range(7) == 0) begin
                    pe_done[k] = 1'b1;
                    exp_ovr    = 1'b1;
                end
            end
            start   = stray_start && ($urandom_range(3) == 0);
            m_ready = 1'($urandom_range(1));
            tick;
            guard++;
            if (left > 0) begin
                chk("collect_valid", m_valid, 0);
                chk("collect_busy", busy, 1);
            end
        end
        chk("collect_timeout", left, 0);
        pe_done = '0;
        start   = 1'b0;
    endtask

    task automatic drain(input int p_ready, input bit stray_start, input bit ovr_inject);
        int idx = 0;
        int guard = 0;
        while (idx < NUM_PE && guard < 500) begin
            chk("drain_valid", m_valid, 1);
            chk("drain_index", m_index, idx);
            chk("drain_data", m_data, exp_buf[idx]);
            chk("drain_last", m_last, idx == NUM_PE - 1);
            chk("drain_busy", busy, 1);
            m_ready = ($urandom_range(99) < p_ready);
            start   = stray_start && ($urandom_range(1) == 1);
            pe_done = '0;
            if (ovr_inject && $urandom_range(5) == 0) begin
                pe_done[$urandom_range(NUM_PE - 1)] = 1'b1;
                exp_ovr = 1'b1;
            end
            tick;
            if (m_ready) idx++;
            guard++;
        end
        chk("drain_timeout", idx, NUM_PE);
        m_ready = 1'b0;
        start   = 1'b0;
        pe_done = '0;
        chk("end_valid", m_valid, 0);
        chk("end_busy", busy, 0);
        chk("end_overrun", overrun, exp_ovr);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; m_ready = 1'b0; pe_done = '0;
        for (int k = 0; k < NUM_PE; k++) pe_out[k] = 16'hffff;
        tick; tick;
        chk("rst_valid", m_valid, 0);
        chk("rst_last", m_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_data", m_data, 0);
        chk("rst_index", m_index, 0);
        rst = 1'b1;
        pe_done = '1;
        tick;
        chk("idle_done_ignored", overrun, 0);
        pe_done = '0;
        tick;

        // all four PEs complete together, full-rate drain
        job_start;
        pe_done = 4'b1111;
        for (int k = 0; k < NUM_PE; k++) begin
            pe_out[k]  = 16'(10 * (k + 1));
            exp_buf[k] = pe_out[k];
        end
        tick;
        pe_done = '0;
        drain(100, 0, 0);

        // PE0 reports again with a different value after capture
        job_start;
        pe_done = 4'b0001; pe_out[0] = 16'd10; exp_buf[0] = 16'd10;
        tick;
        pe_out[0] = 16'd99;
        tick;
        exp_ovr = 1'b1;
        chk("overrun_set", overrun, 1);
        chk("overrun_no_drain", m_valid, 0);
        pe_done = 4'b1110;
        for (int k = 1; k < NUM_PE; k++) begin
            pe_out[k]  = 16'(10 * (k + 1));
            exp_buf[k] = pe_out[k];
        end
        tick;
        pe_done = '0;
        drain(60, 0, 0);

        for (int j = 0; j < 25; j++) begin
            job_start;
            collect($urandom_range(20, 90), j[0], j[1]);
            drain($urandom_range(30, 100), j[2], j[0] & j[1]);
            repeat ($urandom_range(2)) tick;
        end

        // abort in the middle of the stream
        job_start;
        collect(50, 0, 0);
        for (int b = 0; b < 2; b++) begin
            chk("pre_rst_index", m_index, b);
            chk("pre_rst_data", m_data, exp_buf[b]);
            m_ready = 1'b1;
            tick;
        end
        m_ready = 1'b0;
        rst = 1'b0;
        #1;
        chk("abort_valid", m_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_index", m_index, 0);
        chk("abort_data", m_data, 0);
        chk("abort_last", m_last, 0);
        tick;
        rst = 1'b1;
        tick;
        chk("post_rst_idle_valid", m_valid, 0);
        job_start;
        collect(40, 0, 0);
        drain(70, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
